// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one pipelined WxW multiplier among NREQ requesters.
// A {valid,id} tag pipeline routes each product back to the requester that issued it.
module mul_share_sched #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int MUL_LAT = 4,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              mul_en_in,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic              mul_en_out,
  input  logic [2*W-1:0]    mul_out,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [2*W-1:0]    rsp_data,
  output logic              drain_done,
  output logic              err_sticky
);

  localparam int CW = $clog2(MUL_LAT + 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  idx;
  logic [NREQ-1:0] grant;
  logic            found;
  logic            xfer;
  logic [IDW-1:0]  issue_id;
  logic [IDW:0]    tag [MUL_LAT];
  logic            tag_vld;
  logic [IDW-1:0]  tag_id;
  logic [CW-1:0]   inflight;

  // First valid requester at or after ptr wins; only RUN may grant.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    if (state == RUN) begin
      for (int i = 0; i < NREQ; i++) begin
        idx = IDW'((32'(ptr) + i) % NREQ);
        if (!found && req_valid[idx]) begin
          found       = 1'b1;
          grant[idx]  = 1'b1;
          grant_id    = idx;
        end
      end
    end
  end

  assign req_ready = grant;
  assign xfer      = found;
  assign tag_vld   = tag[MUL_LAT-1][IDW];
  assign tag_id    = tag[MUL_LAT-1][IDW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_en_in <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      issue_id  <= '0;
      ptr       <= '0;
    end else begin
      mul_en_in <= xfer;
      issue_id  <= grant_id;
      if (xfer) begin
        mul_a <= req_a[grant_id*W +: W];
        mul_b <= req_b[grant_id*W +: W];
        ptr   <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      end else begin
        mul_a <= '0;
        mul_b <= '0;
      end
    end
  end

  // Tag enters alongside mul_en_in so its last stage lines up with mul_en_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MUL_LAT; k++) tag[k] <= '0;
    end else begin
      tag[0] <= {mul_en_in, issue_id};
      for (int k = 1; k < MUL_LAT; k++) tag[k] <= tag[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= '0;
      rsp_data   <= '0;
      err_sticky <= 1'b0;
      inflight   <= '0;
    end else begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      if (mul_en_out && tag_vld) begin
        rsp_valid <= NREQ'(1) << tag_id;
        rsp_data  <= mul_out;
      end
      if (mul_en_out != tag_vld) err_sticky <= 1'b1;
      // A valid tag retires even on a missing strobe so drain cannot stall.
      case ({xfer, tag_vld})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (!en) state <= DRAIN;
        DRAIN: begin
          if (inflight == '0 && rsp_valid == '0) begin
            state      <= IDLE;
            drain_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed bench for mul_share_sched: vector table for arbitration/throughput,
// hand sequences for single issue, drain, strobe mismatch and mid-flight reset.
module tb_mul_share_sched;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LAT  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              mul_en_in;
  logic [W-1:0]      mul_a, mul_b;
  logic              mul_en_out;
  logic [2*W-1:0]    mul_out;
  logic [NREQ-1:0]   rsp_valid;
  logic [2*W-1:0]    rsp_data;
  logic              drain_done, err_sticky;
  logic              force_en = 1'b0;

  mul_share_sched #(.NREQ(NREQ), .W(W), .MUL_LAT(LAT), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_en_in(mul_en_in), .mul_a(mul_a), .mul_b(mul_b),
    .mul_en_out(mul_en_out), .mul_out(mul_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .drain_done(drain_done), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // Multiplier model: LAT-stage pipeline sharing rst_n.
  logic           pipe_en [LAT];
  logic [2*W-1:0] pipe_p  [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) begin
        pipe_en[k] <= 1'b0;
        pipe_p[k]  <= '0;
      end
    end else begin
      pipe_en[0] <= mul_en_in;
      pipe_p[0]  <= {8'b0, mul_a} * {8'b0, mul_b};
      for (int k = 1; k < LAT; k++) begin
        pipe_en[k] <= pipe_en[k-1];
        pipe_p[k]  <= pipe_p[k-1];
      end
    end
  end
  assign mul_en_out = pipe_en[LAT-1] | force_en;
  assign mul_out    = pipe_p[LAT-1];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rsp_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: transfer at cycle H -> issue at H+1, response at H+6.
  typedef struct {
    int             id;
    logic [2*W-1:0] prod;
    int             due;
  } exp_t;
  exp_t exp_q[$];
  logic       iss_pend = 1'b0;
  logic [7:0] iss_a = '0, iss_b = '0;
  logic [15:0] p;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      iss_pend = 1'b0;
    end else begin
      check("issue", {15'b0, mul_en_in, mul_a, mul_b},
            iss_pend ? {15'b0, 1'b1, iss_a, iss_b} : 32'b0);
      if (rsp_valid != '0) rsp_count++;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        check("rsp", {12'b0, rsp_valid, rsp_data},
              {12'b0, 4'(1 << exp_q[0].id), exp_q[0].prod});
        void'(exp_q.pop_front());
      end else begin
        check("rsp_idle", {12'b0, rsp_valid, rsp_data}, 32'b0);
      end
      check("onehot", {31'b0, ($countones(req_ready) > 1)}, 32'b0);
      iss_pend = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          iss_pend = 1'b1;
          iss_a = req_a[i*8 +: 8];
          iss_b = req_b[i*8 +: 8];
          p = {8'b0, iss_a} * {8'b0, iss_b};
          exp_q.push_back('{i, p, cyc + 6});
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string pfx);
    check({pfx, "_ready"}, 32'(req_ready), 'h0);
    check({pfx, "_issue"}, {15'b0, mul_en_in, mul_a, mul_b}, 'h0);
    check({pfx, "_rsp"}, {12'b0, rsp_valid, rsp_data}, 'h0);
    check({pfx, "_done"}, 32'(drain_done), 'h0);
    check({pfx, "_err"}, 32'(err_sticky), 'h0);
  endtask

  typedef struct {
    logic              en;
    logic [NREQ-1:0]   valid;
    logic [NREQ*W-1:0] a;
    logic [NREQ*W-1:0] b;
    logic [NREQ-1:0]   exp_ready;
  } vec_t;
  localparam int NV = 16;
  vec_t vec [NV];

  int rc0;
  int got;

  initial begin
    // All four busy with 255*255: strict rotation from ptr=0.
    for (int r = 0; r < 8; r++)
      vec[r] = '{1'b1, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'(1 << (r % 4))};
    // req1/req3 alternate, then req2 joins after the grant to req3.
    vec[8]  = '{1'b1, 4'b1010, 32'h4030_2010, 32'h0403_0201, 4'b0010};
    vec[9]  = '{1'b1, 4'b1010, 32'h4030_2010, 32'h0403_0201, 4'b1000};
    vec[10] = '{1'b1, 4'b1010, 32'h4030_2010, 32'h0403_0201, 4'b0010};
    vec[11] = '{1'b1, 4'b1010, 32'h4030_2010, 32'h0403_0201, 4'b1000};
    vec[12] = '{1'b1, 4'b1110, 32'h4030_2010, 32'h0403_0201, 4'b0010};
    vec[13] = '{1'b1, 4'b1110, 32'h4030_2010, 32'h0403_0201, 4'b0100};
    vec[14] = '{1'b1, 4'b1110, 32'h4030_2010, 32'h0403_0201, 4'b1000};
    vec[15] = '{1'b1, 4'b0000, 32'h4030_2010, 32'h0403_0201, 4'b0000};

    repeat (2) tick;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick;
    en = 1'b1;
    tick;

    for (int r = 0; r < NV; r++) begin
      en        = vec[r].en;
      req_valid = vec[r].valid;
      req_a     = vec[r].a;
      req_b     = vec[r].b;
      #1;
      check($sformatf("vec%0d_ready", r), 32'(req_ready), 32'(vec[r].exp_ready));
      tick;
    end
    req_valid = '0;
    repeat (8) tick;

    // Single issue from req0: 3*5=15 six cycles after the transfer.
    req_valid = 4'b0001;
    req_a = 32'h0000_0003;
    req_b = 32'h0000_0005;
    #1;
    check("t1_ready", 32'(req_ready), 'h1);
    tick;
    req_valid = '0;
    check("t1_issue", {15'b0, mul_en_in, mul_a, mul_b}, {15'b0, 1'b1, 8'd3, 8'd5});
    repeat (4) tick;
    check("t1_early", 32'(rsp_valid), 'h0);
    tick;
    check("t1_rsp", {12'b0, rsp_valid, rsp_data}, {12'b0, 4'b0001, 16'd15});
    tick;
    check("t1_after", 32'(rsp_valid), 'h0);

    // Three ops then en falls with the third transfer; en rises again mid-drain.
    rc0 = rsp_count;
    req_valid = 4'b0111;
    req_a = 32'h0009_0705;
    req_b = 32'h0008_0604;
    #1;
    check("t4_g1", 32'(req_ready), 'h2);
    tick;
    check("t4_g2", 32'(req_ready), 'h4);
    tick;
    en = 1'b0;
    #1;
    check("t4_g0_last", 32'(req_ready), 'h1);
    tick;
    check("t4_drain_ready", 32'(req_ready), 'h0);
    check("t4_drain_early", 32'(drain_done), 'h0);
    tick;
    en = 1'b1;
    #1;
    check("t4_en_in_drain", 32'(req_ready), 'h0);
    check("t4_drain_early2", 32'(drain_done), 'h0);
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      tick;
      if (drain_done) got = 1;
    end
    check("t4_drain_seen", got, 1);
    check("t4_rsp_count", rsp_count - rc0, 3);
    check("t4_idle_ready", 32'(req_ready), 'h0);
    tick;
    check("t4_done_pulse", 32'(drain_done), 'h0);
    check("t4_run_again", 32'(req_ready), 'h2);
    req_valid = '0;
    repeat (8) tick;

    // Stray strobe with empty tags: sticky error, no response.
    en = 1'b0;
    repeat (4) tick;
    force_en = 1'b1;
    tick;
    force_en = 1'b0;
    check("t5_err", 32'(err_sticky), 'h1);
    check("t5_no_rsp", 32'(rsp_valid), 'h0);
    repeat (5) tick;
    check("t5_err_hold", 32'(err_sticky), 'h1);
    check("t5_no_rsp_hold", 32'(rsp_valid), 'h0);

    // Reset with four ops in flight.
    en = 1'b1;
    tick;
    req_valid = 4'b1111;
    req_a = 32'h1122_3344;
    req_b = 32'h0506_0708;
    repeat (4) tick;
    rc0 = rsp_count;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    tick;
    tick;
    req_valid = '0;
    rst_n = 1'b1;
    repeat (12) tick;
    check("t6_no_rsp", rsp_count - rc0, 0);
    check("t6_err_clear", 32'(err_sticky), 'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
